// File: rtl/microwave_control.sv
// Control FSM for the MM:SS microwave timer: edge-detects the front-panel buttons, gates the
// counter's load/enable/clear strobes and drives the magnetron and end-of-cook outputs.
module microwave_control #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned DONE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       zero,
  output logic       timer_load,
  output logic       timer_enable,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DONE_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCook  = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] done_cnt_q, done_cnt_d;
  logic          start_q, start_q2, stop_q, stop_q2, cancel_q, cancel_q2;
  logic          start_edge, stop_edge, cancel_edge;
  logic          presc_wrap, done_last;

  assign start_edge  = start_q & ~start_q2;
  assign stop_edge   = stop_q & ~stop_q2;
  assign cancel_edge = cancel_q & ~cancel_q2;
  assign presc_wrap  = (presc_q == PW'(TICK_DIV - 1));
  assign done_last   = (done_cnt_q == DW'(DONE_CYCLES - 1));

  // Button registers reset high so a button held through reset never yields an edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      done_cnt_q <= '0;
      start_q    <= 1'b1;
      start_q2   <= 1'b1;
      stop_q     <= 1'b1;
      stop_q2    <= 1'b1;
      cancel_q   <= 1'b1;
      cancel_q2  <= 1'b1;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      done_cnt_q <= done_cnt_d;
      start_q    <= start;
      start_q2   <= start_q;
      stop_q     <= stop;
      stop_q2    <= stop_q;
      cancel_q   <= cancel;
      cancel_q2  <= cancel_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!cancel_edge && !stop_edge && start_edge && door_closed && !zero) begin
          state_d = StCook;
        end
      end
      StCook: begin
        if (cancel_edge) begin
          state_d = StIdle;
        end else if (!door_closed || stop_edge) begin
          state_d = StPause;
        end else if (zero) begin
          state_d = StDone;
        end
      end
      StPause: begin
        if (cancel_edge || stop_edge) begin
          state_d = StIdle;
        end else if (start_edge && door_closed) begin
          state_d = StCook;
        end
      end
      StDone: begin
        if (cancel_edge || start_edge || done_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Prescaler restarts on every COOK entry so a resume always waits a full tick.
  always_comb begin
    presc_d = presc_q;
    if (state_d == StCook && state_q != StCook) begin
      presc_d = '0;
    end else if (state_q == StCook) begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    end
    done_cnt_d = (state_q == StDone) ? done_cnt_q + DW'(1) : '0;
  end

  always_comb begin
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    timer_clear  = clear;
    unique case (state_q)
      StIdle: begin
        timer_load = key_valid & ~clear;
        if (cancel_edge) timer_clear = 1'b1;
      end
      StCook: begin
        timer_enable = presc_wrap & ~zero & door_closed & ~stop_edge & ~cancel_edge & ~clear;
        if (cancel_edge) timer_clear = 1'b1;
      end
      StPause: begin
        if (cancel_edge || stop_edge) timer_clear = 1'b1;
      end
      default: ;
    endcase
  end

  assign mag_on = (state_q == StCook);
  assign done   = (state_q == StDone);
  assign state  = state_q;

endmodule

// File: tb/tb_microwave_control.sv
// Scoreboard bench for microwave_control: stimulus pushes expected output events (with cycle
// stamps), a negedge monitor pops and compares whenever the DUT shows a strobe or state change.
module tb_microwave_control;

  localparam int unsigned TickDiv    = 4;
  localparam int unsigned DoneCycles = 3;

  logic       clk = 1'b0;
  logic       clear, start, stop, cancel, door_closed, key_valid, zero;
  logic       timer_load, timer_enable, timer_clear, mag_on, done;
  logic [1:0] state;
  logic [7:0] cnt;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  st;
    logic        mag;
    logic        dn;
    logic        ld;
    logic        en;
    logic        clr;
  } ev_t;

  ev_t exp_q[$];

  microwave_control #(
    .TICK_DIV    (TickDiv),
    .DONE_CYCLES (DoneCycles)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .stop         (stop),
    .cancel       (cancel),
    .door_closed  (door_closed),
    .key_valid    (key_valid),
    .zero         (zero),
    .timer_load   (timer_load),
    .timer_enable (timer_enable),
    .timer_clear  (timer_clear),
    .mag_on       (mag_on),
    .done         (done),
    .state        (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural seconds counter; every keypad load writes 3.
  always @(posedge clk) begin
    if (timer_clear) cnt <= 8'd0;
    else if (timer_load) cnt <= 8'd3;
    else if (timer_enable && cnt != 8'd0) cnt <= cnt - 8'd1;
  end
  assign zero = (cnt == 8'd0);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_ev(input int unsigned c, input logic [1:0] st, input logic mag,
                        input logic dn, input logic ld, input logic en, input logic clr);
    ev_t e;
    e = '{c, st, mag, dn, ld, en, clr};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  logic [1:0] prev_st  = 2'd0;
  logic       prev_mag = 1'b0;
  logic       prev_dn  = 1'b0;

  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    act = '{cyc, state, mag_on, done, timer_load, timer_enable, timer_clear};
    if (timer_load || timer_enable || timer_clear || state !== prev_st ||
        mag_on !== prev_mag || done !== prev_dn) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d st=%0d mag=%0b dn=%0b ld=%0b en=%0b clr=%0b",
                 act.cyc, act.st, act.mag, act.dn, act.ld, act.en, act.clr);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display({"FAIL event got cyc=%0d st=%0d mag=%0b dn=%0b ld=%0b en=%0b clr=%0b",
                    " want cyc=%0d st=%0d mag=%0b dn=%0b ld=%0b en=%0b clr=%0b"},
                   act.cyc, act.st, act.mag, act.dn, act.ld, act.en, act.clr,
                   e.cyc, e.st, e.mag, e.dn, e.ld, e.en, e.clr);
        end
      end
    end
    prev_st  = state;
    prev_mag = mag_on;
    prev_dn  = done;
  end

  initial begin
    int unsigned c;
    clear = 1'b1; start = 1'b1; stop = 1'b0; cancel = 1'b0;
    door_closed = 1'b1; key_valid = 1'b0;

    // Reset with start held: timer_clear follows clear, no COOK afterwards.
    exp_ev(1, 2'd0, 0, 0, 0, 0, 1);
    exp_ev(2, 2'd0, 0, 0, 0, 0, 1);
    step(2);
    check("clear_drives_timer_clear", {7'd0, timer_clear}, 8'd1);
    step(1);
    clear = 1'b0;
    step(1);
    check("reset_outputs", {2'd0, state, mag_on, done, timer_load, timer_enable}, 8'd0);
    step(2);
    check("held_start_no_cook", {6'd0, state}, 8'd0);
    start = 1'b0;
    step(2);

    // Keypad load in IDLE.
    key_valid = 1'b1;
    exp_ev(cyc, 2'd0, 0, 0, 1, 0, 0);
    step(1);
    key_valid = 1'b0;

    // Full cook from 00:03.
    c = cyc;
    start = 1'b1;
    exp_ev(c + 2,  2'd1, 1, 0, 0, 0, 0);
    exp_ev(c + 5,  2'd1, 1, 0, 0, 1, 0);
    exp_ev(c + 9,  2'd1, 1, 0, 0, 1, 0);
    exp_ev(c + 13, 2'd1, 1, 0, 0, 1, 0);
    exp_ev(c + 15, 2'd3, 0, 1, 0, 0, 0);
    exp_ev(c + 18, 2'd0, 0, 0, 0, 0, 0);
    step(3);
    start = 1'b0;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    step(13);
    check("done_high", {5'd0, state, done}, 8'h07);
    step(3);

    // Door opened on the second wrap, start refused while open, resume after closing.
    c = cyc;
    key_valid = 1'b1;
    exp_ev(c, 2'd0, 0, 0, 1, 0, 0);
    step(1);
    key_valid = 1'b0;
    start = 1'b1;
    exp_ev(c + 3,  2'd1, 1, 0, 0, 0, 0);
    exp_ev(c + 6,  2'd1, 1, 0, 0, 1, 0);
    exp_ev(c + 11, 2'd2, 0, 0, 0, 0, 0);
    exp_ev(c + 18, 2'd1, 1, 0, 0, 0, 0);
    exp_ev(c + 21, 2'd1, 1, 0, 0, 1, 0);
    exp_ev(c + 23, 2'd1, 1, 0, 0, 0, 1);
    exp_ev(c + 24, 2'd0, 0, 0, 0, 0, 0);
    step(2);
    start = 1'b0;
    step(7);
    door_closed = 1'b0;
    step(2);
    start = 1'b1;
    step(2);
    check("pause_open_door_start", {6'd0, state}, 8'd2);
    start = 1'b0;
    door_closed = 1'b1;
    step(2);
    start = 1'b1;
    step(2);
    start = 1'b0;
    step(4);
    cancel = 1'b1;
    step(2);
    cancel = 1'b0;

    // Refusals: counter at zero, then door open.
    start = 1'b1;
    step(3);
    check("start_zero_refused", {6'd0, state}, 8'd0);
    start = 1'b0;
    step(2);
    key_valid = 1'b1;
    exp_ev(cyc, 2'd0, 0, 0, 1, 0, 0);
    step(1);
    key_valid = 1'b0;
    door_closed = 1'b0;
    start = 1'b1;
    step(3);
    check("start_door_open_refused", {6'd0, state}, 8'd0);
    start = 1'b0;
    door_closed = 1'b1;
    step(2);

    // Stop in COOK pauses; stop in PAUSE clears and idles.
    c = cyc;
    start = 1'b1;
    exp_ev(c + 2, 2'd1, 1, 0, 0, 0, 0);
    exp_ev(c + 5, 2'd2, 0, 0, 0, 0, 0);
    exp_ev(c + 8, 2'd2, 0, 0, 0, 0, 1);
    exp_ev(c + 9, 2'd0, 0, 0, 0, 0, 0);
    step(2);
    start = 1'b0;
    step(1);
    stop = 1'b1;
    step(2);
    stop = 1'b0;
    step(2);
    stop = 1'b1;
    step(2);
    stop = 1'b0;
    step(1);

    // Stop and cancel together in COOK: cancel wins.
    c = cyc;
    key_valid = 1'b1;
    exp_ev(c, 2'd0, 0, 0, 1, 0, 0);
    step(1);
    key_valid = 1'b0;
    start = 1'b1;
    exp_ev(c + 3, 2'd1, 1, 0, 0, 0, 0);
    exp_ev(c + 5, 2'd1, 1, 0, 0, 0, 1);
    exp_ev(c + 6, 2'd0, 0, 0, 0, 0, 0);
    step(2);
    start = 1'b0;
    step(1);
    stop = 1'b1;
    cancel = 1'b1;
    step(2);
    stop = 1'b0;
    cancel = 1'b0;
    step(1);
    check("stop_cancel_idle", {6'd0, state}, 8'd0);
    step(4);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d pending want=0, first cyc=%0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/microwave_control.md
# microwave_control

Control FSM for the level-2 microwave timer. Sits directly upstream of the MM:SS countdown counter and drives its `load`, `enable` and `clear` inputs from the front-panel buttons, door switch and keypad strobe. It consumes the counter's `zero` flag and drives the magnetron and end-of-cook signal. Keypad digits go straight to the counter's `data` bus; this block only gates the load strobe.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per countdown step (1 s at 50 MHz). Must be ≥ 2.
- `DONE_CYCLES`, 3: cycles `done` stays high after the count reaches zero. Must be ≥ 1.

- `clk`  in  1  system clock, all logic on rising edge
- `clear`  in  1  synchronous, active-high reset
- `start`  in  1  start/resume button, level
- `stop`  in  1  pause button, level
- `cancel`  in  1  cancel button, level
- `door_closed`  in  1  1 = door closed
- `key_valid`  in  1  one-cycle strobe: keypad digit present on counter `data`
- `zero`  in  1  counter reads 00:00
- `timer_load`  out  1  to counter `load`
- `timer_enable`  out  1  to counter `enable`, one-cycle decrement pulse
- `timer_clear`  out  1  to counter `clear`
- `mag_on`  out  1  magnetron on
- `done`  out  1  end-of-cook indication
- `state`  out  2  IDLE=0, COOK=1, PAUSE=2, DONE=3

## Operation
- Buttons are rising-edge detected. Each button has a sample register `b_q` and a previous register `b_q2`, and `b_edge = b_q & ~b_q2`. Both registers reset to 1, so a button held through reset produces no edge.
- Button priority when several edges coincide: cancel > stop > start.
- IDLE:
  - `timer_load = key_valid`.
  - `start_edge & door_closed & ~zero` → COOK.
  - `cancel_edge` → `timer_clear`, stay IDLE.
  - Start with the door open or `zero=1` is ignored.
- COOK:
  - `mag_on = 1`.
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - `timer_enable = (presc == TICK_DIV-1) & ~zero & door_closed & ~stop_edge & ~cancel_edge`.
  - Transitions: `cancel_edge` → IDLE with `timer_clear`. `~door_closed` or `stop_edge` → PAUSE. `zero` → DONE.
  - `key_valid` is ignored.
- PAUSE:
  - mag off, prescaler held.
  - `start_edge & door_closed` → COOK.
  - `stop_edge` or `cancel_edge` → IDLE with `timer_clear`.
  - `start_edge` with the door open is ignored.
- DONE:
  - `done = 1`; a counter runs DONE_CYCLES cycles, then → IDLE.
  - `cancel_edge` or `start_edge` → IDLE immediately.
  - A start in DONE does not restart cooking.
- The prescaler clears to 0 on every entry to COOK, so every resume waits a full TICK_DIV period.
- `timer_load`, `timer_enable` and `timer_clear` are combinational from the registered state and the edge flags. `mag_on`, `done` and `state` decode the state register only.

## Timing
- While `clear=1`:
  - `timer_clear = 1`, so the counter resets alongside this block.
  - Next edge sets state=IDLE, prescaler=0, done counter=0, button registers=1.
  - After that edge, `mag_on`, `done`, `timer_enable` and `timer_load` are all 0.
- `clear` mid-cook wins over every other input: IDLE on the next edge.
- Button latency:
  - Button sampled high at edge k (low at k-1) → `*_edge` high during cycle k..k+1.
  - State changes at edge k+1, and `mag_on` follows at edge k+1.
- First decrement: `timer_enable` pulses in the cycle before edge k+1+TICK_DIV, then every TICK_DIV cycles.
- Door opening at edge m:
  - `timer_enable` is suppressed in that same cycle.
  - PAUSE and `mag_on=0` take effect at edge m+1.
- A prescaler wrap and `zero=1` in the same cycle produce no enable pulse. DONE takes effect at the next edge.
- `done` is high for exactly DONE_CYCLES cycles, then IDLE.
- `timer_clear` from cancel/stop lasts one cycle, aligned with the edge flag.

## Test plan
- Reset: drive `clear=1` for 2 cycles with `start` held high, then release.
  - During reset, `timer_clear=1`.
  - After reset, state=0 and all other outputs are 0.
  - No COOK entry until `start` goes low and then high again.
- Entry: pulse `key_valid` in IDLE → `timer_load=1` in that cycle only. Pulse `key_valid` in COOK → `timer_load=0`.
- Full cook (TICK_DIV=4, DONE_CYCLES=3, behavioural counter loaded 00:03): press start.
  - `mag_on` rises 2 edges after the press.
  - Exactly 3 `timer_enable` pulses, 4 cycles apart.
  - `zero` → state DONE, `done` high 3 cycles, then IDLE.
  - `mag_on=0` from DONE entry onward.
- Door: open the door at the cycle of the 2nd prescaler wrap.
  - No enable pulse at that wrap; PAUSE and `mag_on=0` next edge.
  - Start with the door open → stays PAUSE.
  - Close the door, then start → COOK, and the next enable comes 4 cycles later.
- Refusals: start with `zero=1` → stays IDLE; start with the door open → stays IDLE.
- Cancel/stop:
  - Cancel in COOK → one-cycle `timer_clear`, then IDLE.
  - Stop in PAUSE → one-cycle `timer_clear`, then IDLE.
  - Stop and cancel rising in the same cycle during COOK → IDLE (cancel wins).
